// File: rtl/bit64_addsub_pkg.sv
// Shared constants and types for the 64-bit adder/subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: ADDSUB_W word width, OP_ADD/OP_SUB mode encodings on c_in,
//           word_t signed data word, is_sub() mode decode helper.
package bit64_addsub_pkg;

  localparam int ADDSUB_W = 64;

  // c_in doubles as the operation select and the carry into bit 0.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef logic signed [ADDSUB_W-1:0] word_t;

  function automatic logic is_sub(input logic op);
    return (op == OP_SUB) && (op != OP_ADD);
  endfunction

endpackage

// File: rtl/full_adder_1b.sv
// One-bit gate-level full adder, the cell of the ripple carry chain.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b, cin - addend bits and carry in
//        s         - sum bit (a ^ b ^ cin)
//        cout      - carry out (a&b | (a^b)&cin)
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic half_sum;
  logic gen;
  logic prop;

  xor u_x1 (half_sum, a, b);
  xor u_x2 (s, half_sum, cin);
  and u_a1 (gen, a, b);
  and u_a2 (prop, half_sum, cin);
  or  u_o1 (cout, gen, prop);

endmodule

// File: rtl/bit64_add_sub.sv
// 64-bit two's-complement add/sub (c_in=0: a+b, c_in=1: a-b) for the ALU.
// Latency: 1 cycle, result and flags registered together.
// Backpressure: none; accepts a new operation every cycle.
// Ports: clk, rst (async, active high)
//        a, b       - operands, signed two's complement
//        c_in       - mode and carry-in: 0 add, 1 subtract
//        sum        - registered result modulo 2^64
//        c_out      - registered carry out of bit 63 (no-borrow on subtract)
//        overflow   - registered signed overflow
//        zf, sf     - registered sum==0 and sum[63]; present only with
//                     macro ADDSUB_CC_EN defined
module bit64_add_sub
  import bit64_addsub_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDSUB_W-1:0] a,
  input  logic [ADDSUB_W-1:0] b,
  input  logic                c_in,
  output word_t               sum,
  output logic                c_out,
`ifdef ADDSUB_CC_EN
  output logic                overflow,
  output logic                zf,
  output logic                sf
`else
  output logic                overflow
`endif
);

  logic                mode_sub;
  logic [ADDSUB_W-1:0] b_mod;
  logic [ADDSUB_W:0]   carry;
  logic [ADDSUB_W-1:0] sum_d;
  logic                ovf_d;

  assign mode_sub = is_sub(c_in);

  // Subtract is a + ~b + 1: invert b and feed the +1 in as the carry into bit 0.
  assign b_mod    = b ^ {ADDSUB_W{mode_sub}};
  assign carry[0] = mode_sub;

  genvar i;
  generate
    for (i = 0; i < ADDSUB_W; i++) begin : g_rca
      full_adder_1b u_fa (
        .a   (a[i]),
        .b   (b_mod[i]),
        .cin (carry[i]),
        .s   (sum_d[i]),
        .cout(carry[i+1])
      );
    end
  endgenerate

  // Signed overflow: carry into the sign bit disagrees with carry out of it.
  assign ovf_d = carry[ADDSUB_W-1] ^ carry[ADDSUB_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      sum      <= word_t'(sum_d);
      c_out    <= carry[ADDSUB_W];
      overflow <= ovf_d;
    end
  end

`ifdef ADDSUB_CC_EN
  // Flags derive from the unregistered sum so they land in the same cycle as sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zf <= 1'b0;
      sf <= 1'b0;
    end else begin
      zf <= (sum_d == '0);
      sf <= sum_d[ADDSUB_W-1];
    end
  end
`endif

endmodule

// File: tb/tb_bit64_add_sub.sv
module tb_bit64_add_sub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] a   = '0;
  logic [63:0] b   = '0;
  logic        c_in = 1'b0;
  logic [63:0] sum;
  logic        c_out;
  logic        overflow;
`ifdef ADDSUB_CC_EN
  logic        zf;
  logic        sf;
`endif

  int n_vec = 0;
  int n_bad = 0;
  logic cmp_en = 1'b0;

  bit64_add_sub dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .c_in    (c_in),
    .sum     (sum),
    .c_out   (c_out),
`ifdef ADDSUB_CC_EN
    .overflow(overflow),
    .zf      (zf),
    .sf      (sf)
`else
    .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  // Reference from integer arithmetic on sign-extended operands.
  function automatic void model(input logic [63:0] ma, input logic [63:0] mb,
                                input logic sub, output logic [63:0] s,
                                output logic co, output logic ov);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [65:0] xa;
    logic signed [65:0] xb;
    logic signed [65:0] r;
    logic [64:0] u;
    sa = ma;
    sb = mb;
    xa = sa;
    xb = sb;
    if (sub) begin
      r  = xa - xb;
      s  = ma - mb;
      co = (ma >= mb);
    end else begin
      r  = xa + xb;
      u  = {1'b0, ma} + {1'b0, mb};
      s  = u[63:0];
      co = u[64];
    end
    ov = (r > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (r < -66'sh0_8000_0000_0000_0000);
  endfunction

  logic [63:0] exp_sum = '0;
  logic        exp_co  = 1'b0;
  logic        exp_ov  = 1'b0;
  logic        exp_zf  = 1'b0;
  logic        exp_sf  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_sum = '0;
      exp_co  = 1'b0;
      exp_ov  = 1'b0;
      exp_zf  = 1'b0;
      exp_sf  = 1'b0;
    end else begin
      model(a, b, c_in, exp_sum, exp_co, exp_ov);
      exp_zf = (exp_sum == 64'd0);
      exp_sf = exp_sum[63];
    end
  end

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%016h, required 0x%016h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp("model.sum", sum, exp_sum);
      cmp("model.c_out", {63'd0, c_out}, {63'd0, exp_co});
      cmp("model.overflow", {63'd0, overflow}, {63'd0, exp_ov});
`ifdef ADDSUB_CC_EN
      cmp("model.zf", {63'd0, zf}, {63'd0, exp_zf});
      cmp("model.sf", {63'd0, sf}, {63'd0, exp_sf});
`endif
    end
  end

  task automatic check_lit(input string name, input logic [63:0] es,
                           input logic ec, input logic eov, input logic cc_zero);
    cmp({name, ".sum"}, sum, es);
    cmp({name, ".c_out"}, {63'd0, c_out}, {63'd0, ec});
    cmp({name, ".overflow"}, {63'd0, overflow}, {63'd0, eov});
`ifdef ADDSUB_CC_EN
    cmp({name, ".zf"}, {63'd0, zf}, {63'd0, (es == 64'd0) && !cc_zero});
    cmp({name, ".sf"}, {63'd0, sf}, {63'd0, es[63] && !cc_zero});
`else
    if (cc_zero) begin end
`endif
  endtask

  // Drive between edges, then check just after the edge that samples the operands.
  task automatic run_lit(input string name, input logic [63:0] va, input logic [63:0] vb,
                         input logic vc, input logic [63:0] es, input logic ec, input logic eov);
    @(posedge clk);
    #2;
    a = va;
    b = vb;
    c_in = vc;
    @(posedge clk);
    #1;
    check_lit(name, es, ec, eov, 1'b0);
  endtask

  initial begin
    #1;
    check_lit("reset", 64'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    cmp_en = 1'b1;

    run_lit("t1_add_mixed", 64'h4000000000000000, 64'hBFFFFFFFFFFFFFFF, 1'b0,
            64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0);
    run_lit("t2_add_posovf", 64'h4000000000000001, 64'h4000000000000001, 1'b0,
            64'h8000000000000002, 1'b0, 1'b1);
    run_lit("t3_add_negovf", 64'h8000000000000000, 64'h8000000000000000, 1'b0,
            64'h0000000000000000, 1'b1, 1'b1);
    run_lit("t4a_sub_5_3", 64'd5, 64'd3, 1'b1, 64'd2, 1'b1, 1'b0);
    run_lit("t4b_sub_3_5", 64'd3, 64'd5, 1'b1, 64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b0);
    run_lit("sub_0_0", 64'd0, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0);
    run_lit("add_wrap", 64'hFFFFFFFFFFFFFFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0);
    run_lit("t5_sub_minneg", 64'h8000000000000000, 64'd1, 1'b1,
            64'h7FFFFFFFFFFFFFFF, 1'b1, 1'b1);

    // Async reset between edges while the outputs hold a nonzero result.
    #3;
    rst = 1'b1;
    #1;
    check_lit("t6_async_rst", 64'd0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_lit("t6_rst_held", 64'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    a = 64'd1;
    b = 64'd2;
    c_in = 1'b0;
    #1;
    check_lit("t6_after_release", 64'd0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check_lit("t6_first_result", 64'd3, 1'b0, 1'b0, 1'b0);

    // Back-to-back operations, corner operands mixed with random ones.
    for (int k = 0; k < 80; k++) begin
      @(posedge clk);
      #2;
      case (k % 5)
        0: a = {$urandom, $urandom};
        1: a = 64'h8000000000000000;
        2: a = 64'h7FFFFFFFFFFFFFFF;
        default: a = {$urandom, $urandom};
      endcase
      case (k % 7)
        0: b = 64'hFFFFFFFFFFFFFFFF;
        1: b = a;
        default: b = {$urandom, $urandom};
      endcase
      c_in = $urandom_range(0, 1) != 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    cmp_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
